mouse_loc_unit: RTL and testbench



---
 rtl/mouse_loc_unit_pkg.sv | 16 +
 rtl/mouse_loc_unit_if.sv | 16 +
 rtl/mouse_loc_unit_cells.sv | 52 +++++
 rtl/mouse_loc_unit.sv | 50 +++++
 tb/tb_mouse_loc_unit.sv | 132 +++++++++++++
 5 files changed

// File: rtl/mouse_loc_unit_pkg.sv
// Shared constants for the maze-mouse location datapath.
// Coordinates are 4-bit; a location packs them as {X, Y}.
package mouse_loc_unit_pkg;
  localparam int LOC_W   = 8;
  localparam int COORD_W = 4;

  localparam logic [1:0] DIR_YDEC = 2'b00;
  localparam logic [1:0] DIR_XINC = 2'b01;
  localparam logic [1:0] DIR_XDEC = 2'b10;
  localparam logic [1:0] DIR_YINC = 2'b11;

  // X-axis moves are the two directions whose bits differ.
  function automatic logic dir_is_x(input logic [1:0] d);
    return d[1] ^ d[0];
  endfunction
endpackage

// File: rtl/mouse_loc_unit_if.sv
// Controller <-> location unit bus: move controls in, locations and edge flag out.
interface mouse_loc_unit_if;
  logic                                   rgLd;
  logic [1:0]                             dir;
  logic                                   adderEn;
  logic                                   pop;
  logic [mouse_loc_unit_pkg::LOC_W-1:0]   popedLoc;
  logic [mouse_loc_unit_pkg::LOC_W-1:0]   curLoc;
  logic [mouse_loc_unit_pkg::LOC_W-1:0]   nxtLoc;
  logic                                   cntReach;

  modport master (output rgLd, dir, adderEn, pop, popedLoc,
                  input  curLoc, nxtLoc, cntReach);
  modport slave  (input  rgLd, dir, adderEn, pop, popedLoc,
                  output curLoc, nxtLoc, cntReach);
endinterface

// File: rtl/mouse_loc_unit_cells.sv
// Leaf cells of the location datapath: gated step adder, 8-bit 2:1 mux,
// and a 4-bit coordinate register with sync active-low reset.
module adder
  import mouse_loc_unit_pkg::*;
(
  input  logic [COORD_W-1:0] a,
  input  logic [COORD_W-1:0] b,
  input  logic               ci,
  input  logic               en,
  output logic [COORD_W-1:0] sum,
  output logic               co
);
  always_comb begin
    {co, sum} = '0;
    if (en) {co, sum} = {1'b0, a} + {1'b0, b} + {{COORD_W{1'b0}}, ci};
  end
endmodule

module mux2To1
  import mouse_loc_unit_pkg::*;
(
  input  logic [LOC_W-1:0] in0,
  input  logic [LOC_W-1:0] in1,
  input  logic             sl,
  output logic [LOC_W-1:0] out
);
  assign out = sl ? in1 : in0;
endmodule

module reg4B
  import mouse_loc_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [COORD_W-1:0] d,
  output logic [COORD_W-1:0] q
);
  logic [COORD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/mouse_loc_unit.sv
// Mouse location registers plus combinational next-location selection:
// one-step move, stack pop, or origin under reset. Moves wrap mod 16.
module mouse_loc_unit
  import mouse_loc_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mouse_loc_unit_if.slave  bus
);
  logic [1:0][COORD_W-1:0] coord;   // [1] = X, [0] = Y
  logic [3:0][LOC_W-1:0]   chain;
  logic                    sl;
  logic [COORD_W-1:0]      add_to, to_add, res, edge_sum;
  logic                    unused_co;

  always_comb begin
    sl       = dir_is_x(bus.dir);
    add_to   = sl ? coord[1] : coord[0];
    to_add   = bus.dir[0] ? 4'h1 : 4'hF;
    // Edge check uses +0 for decrements so a zero coordinate flags too.
    edge_sum = add_to + {{(COORD_W-1){1'b0}}, bus.dir[0]};
  end

  assign bus.cntReach = (edge_sum == '0);

  adder u_add (
    .a(add_to), .b(to_add), .ci(1'b0), .en(bus.adderEn),
    .sum(res), .co(unused_co)
  );

  // Priority chain, lowest priority first: Y move, X move, pop, reset.
  mux2To1 u_mux_y   (.in0(bus.curLoc), .in1({coord[1], res}),
                     .sl(bus.adderEn & ~sl), .out(chain[0]));
  mux2To1 u_mux_x   (.in0(chain[0]), .in1({res, coord[0]}),
                     .sl(bus.adderEn & sl), .out(chain[1]));
  mux2To1 u_mux_pop (.in0(chain[1]), .in1(bus.popedLoc),
                     .sl(bus.pop), .out(chain[2]));
  mux2To1 u_mux_rst (.in0('0), .in1(chain[2]),
                     .sl(rst), .out(chain[3]));

  assign bus.nxtLoc = chain[3];
  assign bus.curLoc = coord;

  for (genvar g = 0; g < 2; g++) begin : g_reg
    reg4B u_reg (
      .clk(clk), .rst(rst), .ld(bus.rgLd),
      .d(bus.nxtLoc[g*COORD_W +: COORD_W]), .q(coord[g])
    );
  end
endmodule

// File: tb/tb_mouse_loc_unit.sv
// Directed test-plan sequences plus random traffic against a coordinate-level model.
module tb_mouse_loc_unit;
  import mouse_loc_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  int   mx, my;          // model coordinates

  mouse_loc_unit_if bus ();
  mouse_loc_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] m_cur();
    logic [3:0] x4, y4;
    x4 = mx[3:0]; y4 = my[3:0];
    return {x4, y4};
  endfunction

  function automatic logic [7:0] m_nxt(input logic r, input logic p, input logic aen,
                                       input logic [1:0] d, input logic [7:0] ploc);
    int x, y;
    logic [3:0] x4, y4;
    x = mx; y = my;
    if (!r) return 8'h00;
    if (p) return ploc;
    if (aen) begin
      case (d)
        DIR_YDEC: y = (y + 15) % 16;
        DIR_XINC: x = (x + 1) % 16;
        DIR_XDEC: x = (x + 15) % 16;
        default:  y = (y + 1) % 16;
      endcase
    end
    x4 = x[3:0]; y4 = y[3:0];
    return {x4, y4};
  endfunction

  function automatic logic m_edge(input logic [1:0] d);
    case (d)
      DIR_YDEC: return my == 0;
      DIR_XINC: return mx == 15;
      DIR_XDEC: return mx == 0;
      default:  return my == 15;
    endcase
  endfunction

  // Drive one cycle's inputs, check the combinational view, then clock.
  task automatic apply(input logic r, input logic ld, input logic [1:0] d,
                       input logic aen, input logic p, input logic [7:0] ploc);
    logic [7:0] exp_n;
    rst = r; bus.rgLd = ld; bus.dir = d; bus.adderEn = aen;
    bus.pop = p; bus.popedLoc = ploc;
    #1;
    exp_n = m_nxt(r, p, aen, d, ploc);
    chk("curLoc", bus.curLoc, m_cur());
    chk("nxtLoc", bus.nxtLoc, exp_n);
    chk("cntReach", {7'b0, bus.cntReach}, {7'b0, m_edge(d)});
    @(posedge clk);
    if (!r)      begin mx = 0; my = 0; end
    else if (ld) begin mx = int'(exp_n[7:4]); my = int'(exp_n[3:0]); end
    @(negedge clk);
  endtask

  task automatic set_loc(input logic [7:0] loc);
    apply(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, loc);
  endtask

  initial begin
    mx = 0; my = 0;
    @(negedge clk);
    // Reset held two cycles, then released without a load.
    apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'hEE);
    apply(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    #1 chk("rst_cur", bus.curLoc, 8'h00);
    apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    #1 chk("rel_cur", bus.curLoc, 8'h00);

    // Four-direction walk from 0x55.
    set_loc(8'h55);
    apply(1'b1, 1'b1, DIR_XINC, 1'b1, 1'b0, 8'h00); #1 chk("xinc", bus.curLoc, 8'h65);
    apply(1'b1, 1'b1, DIR_XDEC, 1'b1, 1'b0, 8'h00); #1 chk("xdec", bus.curLoc, 8'h55);
    apply(1'b1, 1'b1, DIR_YINC, 1'b1, 1'b0, 8'h00); #1 chk("yinc", bus.curLoc, 8'h56);
    apply(1'b1, 1'b1, DIR_YDEC, 1'b1, 1'b0, 8'h00); #1 chk("ydec", bus.curLoc, 8'h55);

    // Grid edges from 0xF0.
    set_loc(8'hF0);
    bus.dir = DIR_XINC; bus.adderEn = 1'b1; bus.pop = 1'b0; bus.rgLd = 1'b0; #1;
    chk("edge_xinc_flag", {7'b0, bus.cntReach}, 8'h01);
    chk("edge_xinc_wrap", bus.nxtLoc, 8'h00);
    bus.dir = DIR_YDEC; #1;
    chk("edge_ydec_flag", {7'b0, bus.cntReach}, 8'h01);
    bus.dir = DIR_YINC; #1;
    chk("edge_yinc_flag", {7'b0, bus.cntReach}, 8'h00);
    chk("edge_yinc_nxt", bus.nxtLoc, 8'hF1);
    apply(1'b1, 1'b0, DIR_XDEC, 1'b1, 1'b0, 8'h00);

    // Pop beats a simultaneous move.
    set_loc(8'h23);
    apply(1'b1, 1'b1, DIR_XINC, 1'b1, 1'b1, 8'hA7);
    #1 chk("pop_cur", bus.curLoc, 8'hA7);

    // Hold: idle selects curLoc; move without load leaves curLoc alone.
    apply(1'b1, 1'b1, DIR_YINC, 1'b0, 1'b0, 8'h11);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, DIR_XINC, 1'b1, 1'b0, 8'h00);
    #1 chk("hold_cur", bus.curLoc, 8'hA7);

    // Reset overrides a committed move.
    set_loc(8'h9C);
    apply(1'b0, 1'b1, DIR_XINC, 1'b1, 1'b0, 8'h00);
    #1 chk("rst_mid", bus.curLoc, 8'h00);

    // Random traffic, reset rare and pop occasional.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 19) != 0), 1'($urandom), 2'($urandom),
            1'($urandom), ($urandom_range(0, 4) == 0), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
